// File: rtl/decode_stage_nw.sv
// N-wide registered RV32I decode stage with a 2-entry skid buffer.
// Ports: fetch bundle in (valid/ready, instr, mask), decoded bundle out.
module decode_stage_nw #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int SEQ_W = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*LANES-1:0]   in_instr,
    input  logic [LANES-1:0]      in_mask,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_mask,
    output logic [7*LANES-1:0]    out_opcode,
    output logic [3*LANES-1:0]    out_funct3,
    output logic [7*LANES-1:0]    out_funct7,
    output logic [5*LANES-1:0]    out_rs1,
    output logic [5*LANES-1:0]    out_rs2,
    output logic [5*LANES-1:0]    out_rd,
    output logic [XLEN*LANES-1:0] out_imm,
    output logic [7*LANES-1:0]    out_ctrl,
    output logic [2*LANES-1:0]    out_aluop,
    output logic [2*LANES-1:0]    out_lwsw,
    output logic [LANES-1:0]      out_illegal,
    output logic [SEQ_W-1:0]      out_seq
);

    typedef struct packed {
        logic            mask;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [6:0]      ctrl;
        logic [1:0]      aluop;
        logic [1:0]      lwsw;
        logic            illegal;
    } lane_t;

    typedef struct packed {
        lane_t [LANES-1:0] lane;
        logic [SEQ_W-1:0]  seq;
    } bundle_t;

    // ctrl = {hasImm, regWrite, aluSrc, branch, memRead, memWrite, memToReg}
    function automatic lane_t dec_lane(input logic [31:0] ins,
                                       input logic vld);
        lane_t       l;
        logic [31:0] imm32;
        logic [6:0]  ctrl;
        logic [1:0]  aluop;
        logic [1:0]  lwsw;
        logic        ill;
        l        = '0;
        imm32    = '0;
        ctrl     = '0;
        aluop    = '0;
        lwsw     = '0;
        ill      = 1'b0;
        l.mask   = vld;
        l.opcode = ins[6:0];
        l.funct3 = ins[14:12];
        l.funct7 = ins[31:25];
        l.rs1    = ins[19:15];
        l.rs2    = ins[24:20];
        l.rd     = ins[11:7];
        case (ins[6:0])
            7'b0110011: begin
                ctrl  = 7'b0100000;
                aluop = 2'b10;
            end
            7'b0010011: begin
                ctrl  = 7'b1110000;
                aluop = 2'b11;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0000011: begin
                ctrl  = 7'b1110101;
                lwsw  = 2'b01;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                ctrl  = 7'b1010010;
                lwsw  = 2'b10;
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                ctrl  = 7'b1001000;
                aluop = 2'b01;
                imm32 = {{19{ins[31]}}, ins[31], ins[7],
                         ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                ctrl  = 7'b1110000;
                imm32 = {ins[31:12], 12'h000};
            end
            7'b1101111: begin
                ctrl  = 7'b1101000;
                imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                         ins[20], ins[30:21], 1'b0};
            end
            7'b1100111: begin
                ctrl  = 7'b1111000;
                imm32 = {{20{ins[31]}}, ins[31:20]};
            end
            default: ill = 1'b1;
        endcase
        // Writes to x0 are architecturally discarded; suppress them here.
        if (ins[11:7] == 5'd0) begin
            ctrl[5] = 1'b0;
        end
        if (vld) begin
            l.imm     = XLEN'($signed(imm32));
            l.ctrl    = ctrl;
            l.aluop   = aluop;
            l.lwsw    = lwsw;
            l.illegal = ill;
        end
        return l;
    endfunction

    bundle_t              in_b;
    bundle_t              out_q, out_d;
    bundle_t              skid_q, skid_d;
    logic                 out_vld_q, out_vld_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 rdy_q, rdy_d;
    logic [SEQ_W-1:0]     seq_q, seq_d;
    logic                 accept;

    always_comb begin
        in_b = '0;
        for (int i = 0; i < LANES; i++) begin
            in_b.lane[i] = dec_lane(in_instr[32*i +: 32], in_mask[i]);
        end
        in_b.seq = seq_q;
    end

    assign accept = in_valid & rdy_q & ~flush;

    always_comb begin
        out_d      = out_q;
        skid_d     = skid_q;
        out_vld_d  = out_vld_q;
        skid_vld_d = skid_vld_q;
        seq_d      = seq_q;
        if (accept) begin
            seq_d = seq_q + 1'b1;
        end
        if (flush) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || out_ready) begin
            // Output slot is free this edge: refill from skid first.
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                out_d     = in_b;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = in_b;
            skid_vld_d = 1'b1;
        end
        // Registered ready breaks any comb path from out_ready.
        rdy_d = ~skid_vld_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            seq_q      <= '0;
        end else begin
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            seq_q      <= seq_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = out_vld_q;
    assign out_seq   = out_q.seq;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            out_mask[i]               = out_q.lane[i].mask;
            out_opcode[7*i +: 7]      = out_q.lane[i].opcode;
            out_funct3[3*i +: 3]      = out_q.lane[i].funct3;
            out_funct7[7*i +: 7]      = out_q.lane[i].funct7;
            out_rs1[5*i +: 5]         = out_q.lane[i].rs1;
            out_rs2[5*i +: 5]         = out_q.lane[i].rs2;
            out_rd[5*i +: 5]          = out_q.lane[i].rd;
            out_imm[XLEN*i +: XLEN]   = out_q.lane[i].imm;
            out_ctrl[7*i +: 7]        = out_q.lane[i].ctrl;
            out_aluop[2*i +: 2]       = out_q.lane[i].aluop;
            out_lwsw[2*i +: 2]        = out_q.lane[i].lwsw;
            out_illegal[i]            = out_q.lane[i].illegal;
        end
    end

endmodule

// File: tb/tb_decode_stage_nw.sv
// Directed scoreboard bench for decode_stage_nw (LANES=2, XLEN=32, SEQ_W=4).
// Expected bundles are queued at accept and compared when drained.
module tb_decode_stage_nw;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_instr;
    logic [1:0]  in_mask;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_mask;
    logic [13:0] out_opcode;
    logic [5:0]  out_funct3;
    logic [13:0] out_funct7;
    logic [9:0]  out_rs1;
    logic [9:0]  out_rs2;
    logic [9:0]  out_rd;
    logic [63:0] out_imm;
    logic [13:0] out_ctrl;
    logic [3:0]  out_aluop;
    logic [3:0]  out_lwsw;
    logic [1:0]  out_illegal;
    logic [3:0]  out_seq;

    always #5 clk = ~clk;

    decode_stage_nw #(.LANES(2), .XLEN(32), .SEQ_W(4)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_opcode(out_opcode),
        .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_ctrl(out_ctrl),
        .out_aluop(out_aluop), .out_lwsw(out_lwsw),
        .out_illegal(out_illegal), .out_seq(out_seq)
    );

    typedef struct {
        logic [3:0]  seq;
        logic [1:0]  mask;
        logic [13:0] op;
        logic [13:0] ctrl;
        logic [3:0]  aluop;
        logic [3:0]  lwsw;
        logic [63:0] imm;
        logic [9:0]  rd;
        logic [1:0]  ill;
    } exp_t;

    exp_t q[$];
    logic [3:0] exp_seq;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] m,
                                input logic [6:0] c0, input logic [6:0] c1,
                                input logic [1:0] a0, input logic [1:0] a1,
                                input logic [1:0] w0, input logic [1:0] w1,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [1:0] il);
        exp_t e;
        e.seq   = '0;
        e.op    = '0;
        e.mask  = m;
        e.ctrl  = {c1, c0};
        e.aluop = {a1, a0};
        e.lwsw  = {w1, w0};
        e.imm   = {i1, i0};
        e.rd    = {r1, r0};
        e.ill   = il;
        return e;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out();
        exp_t e;
        if (out_valid && out_ready) begin
            checks++;
            assert (q.size() > 0) else begin
                errors++;
                $error("FAIL spurious_out: observed seq %0d expected none",
                       out_seq);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("seq", out_seq, e.seq);
                chk("mask", out_mask, e.mask);
                chk("opcode", out_opcode, e.op);
                chk("ctrl", out_ctrl, e.ctrl);
                chk("aluop", out_aluop, e.aluop);
                chk("lwsw", out_lwsw, e.lwsw);
                chk("imm", out_imm, e.imm);
                chk("rd", out_rd, e.rd);
                chk("illegal", out_illegal, e.ill);
            end
        end
    endtask

    task automatic step();
        check_out();
        cyc();
    endtask

    task automatic drive(input logic [31:0] i0, input logic [31:0] i1,
                         input logic [1:0] m, input bit push,
                         input exp_t e);
        exp_t x;
        in_valid = 1'b1;
        in_instr = {i1, i0};
        in_mask  = m;
        if (push) begin
            x     = e;
            x.seq = exp_seq;
            x.op  = {i1[6:0], i0[6:0]};
            exp_seq = exp_seq + 4'd1;
            q.push_back(x);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = '0;
        in_mask  = '0;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return {12'(imm), 5'd0, 3'd0, 5'(rd), 7'h13};
    endfunction

    task automatic send_addi(input int rd, input int imm, input bit push);
        drive(addi(rd, imm), 32'h0, 2'b01, push,
              mk(2'b01, 7'b1110000, 7'd0, 2'b11, 2'b00, 2'b00, 2'b00,
                 32'(imm), 32'd0, 5'(rd), 5'd0, 2'b00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_seq   = '0;
        rstn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_seq", out_seq, 0);
        chk("rst_ctrl", out_ctrl, 0);
        #2 rstn = 1'b1;
        cyc();
        chk("ready_after_rst", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);

        // addi x1,x0,10 in lane 0, lane 1 masked
        drive(32'h00A00093, 32'h0, 2'b01, 1,
              mk(2'b01, 7'b1110000, 7'd0, 2'b11, 2'b00, 2'b00, 2'b00,
                 32'd10, 32'd0, 5'd1, 5'd0, 2'b00));
        step();
        // sw x5,-4(x2) / beq x0,x0,-8
        drive(32'hFE512E23, 32'hFE000CE3, 2'b11, 1,
              mk(2'b11, 7'b1010010, 7'b1001000, 2'b00, 2'b01,
                 2'b10, 2'b00, 32'hFFFFFFFC, 32'hFFFFFFF8,
                 5'd28, 5'd25, 2'b00));
        step();
        // lui x5,0x12345 / lw x3,8(x2)
        drive(32'h123452B7, 32'h00812183, 2'b11, 1,
              mk(2'b11, 7'b1110000, 7'b1110101, 2'b00, 2'b00,
                 2'b00, 2'b01, 32'h12345000, 32'd8,
                 5'd5, 5'd3, 2'b00));
        step();
        // jal x1,16 / jalr x0,0(x1)
        drive(32'h010000EF, 32'h00008067, 2'b11, 1,
              mk(2'b11, 7'b1101000, 7'b1011000, 2'b00, 2'b00,
                 2'b00, 2'b00, 32'd16, 32'd0,
                 5'd1, 5'd0, 2'b00));
        step();
        // bad opcode / add x0,x1,x2 masked off
        drive(32'h0000007F, 32'h00208033, 2'b01, 1,
              mk(2'b01, 7'd0, 7'd0, 2'b00, 2'b00, 2'b00, 2'b00,
                 32'd0, 32'd0, 5'd0, 5'd0, 2'b01));
        step();
        // same with lane 1 enabled: rd=0 kills regWrite
        drive(32'h0000007F, 32'h00208033, 2'b11, 1,
              mk(2'b11, 7'd0, 7'd0, 2'b00, 2'b10, 2'b00, 2'b00,
                 32'd0, 32'd0, 5'd0, 5'd0, 2'b01));
        step();
        idle();
        step();
        step();

        // backpressure: seq 6 in output, 7 in skid, 8 refused
        out_ready = 1'b0;
        send_addi(2, 100, 1);
        chk("bp_ready0", in_ready, 1);
        step();
        send_addi(3, 200, 1);
        step();
        send_addi(4, 300, 0);
        chk("bp_ready_low", in_ready, 0);
        step();
        chk("bp_ready_low2", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_seq", out_seq, 6);
        chk("bp_hold_imm", out_imm, 64'd100);
        step();
        out_ready = 1'b1;
        chk("bp_ready_low3", in_ready, 0);
        step();
        send_addi(4, 300, 1);
        chk("bp_ready_back", in_ready, 1);
        step();
        idle();
        step();
        step();

        // flush with both entries full and in_valid on the edge
        out_ready = 1'b0;
        send_addi(5, 1, 1);
        step();
        send_addi(6, 2, 1);
        step();
        send_addi(7, 3, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        q.delete();
        exp_seq = 4'd11;
        idle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_ready", in_ready, 1);
        // flush while in_ready=1: the bundle must be dropped
        send_addi(8, 4, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        chk("flush2_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send_addi(9, 5, 1);
        step();
        idle();
        step();

        // sequence wrap 15 -> 0
        for (int k = 0; k < 7; k++) begin
            send_addi(10 + k, 20 + k, 1);
            step();
        end
        idle();
        step();
        step();

        // asynchronous reset with both entries full
        out_ready = 1'b0;
        send_addi(11, 6, 1);
        step();
        send_addi(12, 7, 1);
        step();
        idle();
        chk("pre_rst_ready", in_ready, 0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_seq", out_seq, 0);
        chk("arst_ctrl", out_ctrl, 0);
        chk("arst_imm", out_imm, 0);
        chk("arst_mask", out_mask, 0);
        q.delete();
        exp_seq = '0;
        #2 rstn = 1'b1;
        cyc();
        chk("rel_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        out_ready = 1'b1;
        send_addi(13, 8, 1);
        step();
        idle();
        step();
        step();
        chk("queue_empty", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
